fifo_bist_analyzer: RTL and testbench
=====================================

Name: fifo_bist_analyzer

Overview:
- Read-side response analyzer for the FIFO memory BIST.
- Consumes the read strobe, read address and expected data issued by the BIST pattern generator, and aligns them to memory read latency.
- Compares against memory RDATA and accumulates results: sticky pass/fail, saturating fail count, first-fail capture, and a done flag for the test controller.

Parameters:
DATA_WIDTH, 8, memory word width
ADDR_WIDTH, 4, memory address width (depth = 2**ADDR_WIDTH)
READ_LATENCY, 1, cycles from R_INC to valid RDATA; legal 1..4
CNT_WIDTH, 8, fail counter width

Ports:
WCLK  in  1  BIST test clock; all state on rising edge
RST  in  1  asynchronous, active-high reset
BIST_EN  in  1  analyzer enable; low forces IDLE
START  in  1  one-cycle pulse: clear results, begin test
R_INC  in  1  generator issued a read this cycle
R_ADDR  in  ADDR_WIDTH  address of issued read
EXPECTED  in  DATA_WIDTH  expected data for issued read
LAST  in  1  qualifies R_INC as final read of test
RDATA  in  DATA_WIDTH  memory read data
PASSFAIL  out  1  1 = no miscompare since START
DONE  out  1  test complete, results stable
BUSY  out  1  state is RUN or DRAIN
FAIL_CNT  out  CNT_WIDTH  miscompares since START, saturating
FIRST_FAIL_ADDR  out  ADDR_WIDTH  address of first miscompare
FIRST_FAIL_XOR  out  DATA_WIDTH  RDATA ^ EXPECTED at first miscompare

Behaviour:
- Reset values: state IDLE, PASSFAIL=1, DONE=0, BUSY=0, FAIL_CNT=0, FIRST_FAIL_*=0, pipeline valids=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE --(START & BIST_EN)--> RUN. Clears PASSFAIL=1, FAIL_CNT=0, FIRST_FAIL_*=0, DONE=0 and flushes the pipeline.
  - RUN --(R_INC & LAST)--> DRAIN.
  - DRAIN --(pipeline empty after this edge's compare)--> DONE.
  - DONE holds until START.
  - BIST_EN=0 in any state: next state IDLE, pipeline flushed; result registers hold their values.
- START while in RUN or DRAIN is ignored.
- R_INC is accepted only in RUN; it is ignored in IDLE, DRAIN and DONE.
- Alignment pipeline: READ_LATENCY stages of {valid, addr, expected}. Stage 0 loads on an accepted R_INC.
- Compare latency: R_INC at edge n is compared against RDATA sampled at edge n+READ_LATENCY.
- Back-to-back R_INC every cycle is supported with no bubbles.
- Miscompare condition: tail valid & (RDATA != tail expected). On the same edge:
  - PASSFAIL<=0 (sticky).
  - FAIL_CNT increments, saturating at 2**CNT_WIDTH-1.
  - If FAIL_CNT was 0, capture FIRST_FAIL_ADDR and FIRST_FAIL_XOR. Later fails never overwrite them.
- DONE asserts on the edge after the final compare and stays high until START or BIST_EN=0.
- BUSY=1 exactly in RUN/DRAIN.
- Async RST mid-test returns all outputs to reset values immediately.

Optional Feature:
- Macro BIST_MISR_EN.
- Defined:
  - Adds output SIGNATURE [DATA_WIDTH-1:0], seeded to all-ones on START and on reset.
  - On each valid tail compare: SIGNATURE <= ({SIGNATURE[DATA_WIDTH-2:0],1'b0} ^ (SIGNATURE[DATA_WIDTH-1] ? TAPS : 0)) ^ RDATA.
  - TAPS is an extra parameter MISR_TAPS, default 8'hB8.
  - SIGNATURE is stable when DONE=1.
- Undefined: no SIGNATURE port, no MISR logic; everything else identical.

Test Plan:
- Clean run: 16 reads, addr 0..15, EXPECTED=RDATA=0x55, R_INC every cycle, LAST on addr 15 -> PASSFAIL=1, FAIL_CNT=0, DONE high 2 cycles after the last R_INC (READ_LATENCY=1), BUSY low on that same edge.
- Single fault: addr 6 returns 0x57, expected 0x55 -> PASSFAIL=0, FAIL_CNT=1, FIRST_FAIL_ADDR=6, FIRST_FAIL_XOR=0x02.
- Multiple faults: addr 3 XOR 0x80, addr 9 XOR 0x01 -> FAIL_CNT=2, FIRST_FAIL_ADDR=3, FIRST_FAIL_XOR=0x80; CNT_WIDTH=2 with 5 fails -> FAIL_CNT=3.
- Latency/gaps: READ_LATENCY=3, R_INC with idle gaps, RDATA driven correct only 3 cycles after each R_INC -> PASSFAIL=1; same run with RDATA shifted to 2 cycles -> PASSFAIL=0.
- Control edges:
  - START during RUN -> ignored, results unchanged.
  - BIST_EN dropped mid-RUN -> IDLE, DONE=0, captured fail values held.
  - RST asserted mid-RUN -> all outputs at reset values before the next clock edge.
- BIST_MISR_EN: one read with RDATA=0x00 after START -> SIGNATURE=0x46; a second START reseeds SIGNATURE to 0xFF.

Source files
------------

// File: rtl/fifo_bist_analyzer.sv
// Read-side response analyzer for the FIFO memory BIST.
// Aligns issued reads to memory read latency, compares them against RDATA and
// accumulates sticky pass/fail, a saturating fail count and first-fail capture.
// Optional MISR signature output is enabled with macro BIST_MISR_EN.
module fifo_bist_analyzer #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned CNT_WIDTH    = 8
`ifdef BIST_MISR_EN
  ,
  parameter logic [DATA_WIDTH-1:0] MISR_TAPS = 8'hB8
`endif
) (
  input  logic                  WCLK,
  input  logic                  RST,
  input  logic                  BIST_EN,
  input  logic                  START,
  input  logic                  R_INC,
  input  logic [ADDR_WIDTH-1:0] R_ADDR,
  input  logic [DATA_WIDTH-1:0] EXPECTED,
  input  logic                  LAST,
  input  logic [DATA_WIDTH-1:0] RDATA,
  output logic                  PASSFAIL,
  output logic                  DONE,
  output logic                  BUSY,
  output logic [CNT_WIDTH-1:0]  FAIL_CNT,
  output logic [ADDR_WIDTH-1:0] FIRST_FAIL_ADDR,
  output logic [DATA_WIDTH-1:0] FIRST_FAIL_XOR
`ifdef BIST_MISR_EN
  ,
  output logic [DATA_WIDTH-1:0] SIGNATURE
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [ADDR_WIDTH-1:0]   addr_q [READ_LATENCY];
  logic [ADDR_WIDTH-1:0]   addr_d [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   exp_q  [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   exp_d  [READ_LATENCY];

  logic                  pass_q, pass_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] ffa_q, ffa_d;
  logic [DATA_WIDTH-1:0] ffx_q, ffx_d;

  logic clear, accept, cmp_en, miscmp;

  // Control decode shared by the FSM, pipeline and result logic.
  always_comb begin
    clear  = BIST_EN && START && ((state_q == StIdle) || (state_q == StDone));
    accept = BIST_EN && R_INC && (state_q == StRun);
    cmp_en = BIST_EN && vld_q[READ_LATENCY-1];
    miscmp = cmp_en && (RDATA != exp_q[READ_LATENCY-1]);
  end

  // Next state; DRAIN waits until the last compare has already been absorbed.
  always_comb begin
    state_d = state_q;
    if (!BIST_EN) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: if (START)         state_d = StRun;
        StRun:          if (R_INC && LAST) state_d = StDrain;
        StDrain:        if (vld_q == '0)   state_d = StDone;
        default:                           state_d = StIdle;
      endcase
    end
    done_d = (state_d == StDone);
    busy_d = (state_d == StRun) || (state_d == StDrain);
  end

  // Alignment pipeline: stage 0 loads on an accepted read, tail feeds the compare.
  always_comb begin
    vld_d     = '0;
    addr_d    = addr_q;
    exp_d     = exp_q;
    vld_d[0]  = accept;
    if (accept) begin
      addr_d[0] = R_ADDR;
      exp_d[0]  = EXPECTED;
    end
    for (int k = 1; k < READ_LATENCY; k++) begin
      vld_d[k]  = vld_q[k-1];
      addr_d[k] = addr_q[k-1];
      exp_d[k]  = exp_q[k-1];
    end
    if (!BIST_EN || clear) vld_d = '0;
  end

  // Result accumulation; first-fail fields capture only while the count is zero.
  always_comb begin
    pass_d = pass_q;
    cnt_d  = cnt_q;
    ffa_d  = ffa_q;
    ffx_d  = ffx_q;
    if (clear) begin
      pass_d = 1'b1;
      cnt_d  = '0;
      ffa_d  = '0;
      ffx_d  = '0;
    end else if (miscmp) begin
      pass_d = 1'b0;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
      if (cnt_q == '0) begin
        ffa_d = addr_q[READ_LATENCY-1];
        ffx_d = RDATA ^ exp_q[READ_LATENCY-1];
      end
    end
  end

`ifdef BIST_MISR_EN
  logic [DATA_WIDTH-1:0] sig_q, sig_d;

  // MISR folds every tail-compared RDATA word, reseeded to all-ones on START.
  always_comb begin
    sig_d = sig_q;
    if (clear) begin
      sig_d = '1;
    end else if (cmp_en) begin
      sig_d = ({sig_q[DATA_WIDTH-2:0], 1'b0} ^ (sig_q[DATA_WIDTH-1] ? MISR_TAPS : '0)) ^ RDATA;
    end
  end

  // Signature register.
  always_ff @(posedge WCLK or posedge RST) begin
    if (RST) sig_q <= '1;
    else     sig_q <= sig_d;
  end

  assign SIGNATURE = sig_q;
`endif

  // All FSM, pipeline and result state with registered outputs.
  always_ff @(posedge WCLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      vld_q   <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        addr_q[k] <= '0;
        exp_q[k]  <= '0;
      end
      pass_q  <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      ffa_q   <= '0;
      ffx_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      exp_q   <= exp_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      ffa_q   <= ffa_d;
      ffx_q   <= ffx_d;
    end
  end

  assign PASSFAIL        = pass_q;
  assign DONE            = done_q;
  assign BUSY            = busy_q;
  assign FAIL_CNT        = cnt_q;
  assign FIRST_FAIL_ADDR = ffa_q;
  assign FIRST_FAIL_XOR  = ffx_q;

endmodule

// File: tb/tb_fifo_bist_analyzer.sv
// Bench for fifo_bist_analyzer: three instances (latency 1, latency 3, 2-bit counter)
// share the generator stimulus; a memory model drives RDATA per latency.
module tb_fifo_bist_analyzer;

  logic       WCLK, RST, BIST_EN, START, R_INC, LAST;
  logic [3:0] R_ADDR;
  logic [7:0] EXPECTED;
  logic [7:0] rdata1, rdata3;

  logic       pf1, done1, busy1, pf3, done3, busy3, pfc, donec, busyc;
  logic [7:0] cnt1, cnt3, ffx1, ffx3, ffxc;
  logic [1:0] cntc;
  logic [3:0] ffa1, ffa3, ffac;
`ifdef BIST_MISR_EN
  logic [7:0] sig1, sig3, sigc;
`endif

  fifo_bist_analyzer #(.READ_LATENCY(1)) dut1 (
    .WCLK(WCLK), .RST(RST), .BIST_EN(BIST_EN), .START(START), .R_INC(R_INC),
    .R_ADDR(R_ADDR), .EXPECTED(EXPECTED), .LAST(LAST), .RDATA(rdata1),
    .PASSFAIL(pf1), .DONE(done1), .BUSY(busy1), .FAIL_CNT(cnt1),
    .FIRST_FAIL_ADDR(ffa1), .FIRST_FAIL_XOR(ffx1)
`ifdef BIST_MISR_EN
    , .SIGNATURE(sig1)
`endif
  );

  fifo_bist_analyzer #(.READ_LATENCY(3)) dut3 (
    .WCLK(WCLK), .RST(RST), .BIST_EN(BIST_EN), .START(START), .R_INC(R_INC),
    .R_ADDR(R_ADDR), .EXPECTED(EXPECTED), .LAST(LAST), .RDATA(rdata3),
    .PASSFAIL(pf3), .DONE(done3), .BUSY(busy3), .FAIL_CNT(cnt3),
    .FIRST_FAIL_ADDR(ffa3), .FIRST_FAIL_XOR(ffx3)
`ifdef BIST_MISR_EN
    , .SIGNATURE(sig3)
`endif
  );

  fifo_bist_analyzer #(.READ_LATENCY(1), .CNT_WIDTH(2)) dutc (
    .WCLK(WCLK), .RST(RST), .BIST_EN(BIST_EN), .START(START), .R_INC(R_INC),
    .R_ADDR(R_ADDR), .EXPECTED(EXPECTED), .LAST(LAST), .RDATA(rdata1),
    .PASSFAIL(pfc), .DONE(donec), .BUSY(busyc), .FAIL_CNT(cntc),
    .FIRST_FAIL_ADDR(ffac), .FIRST_FAIL_XOR(ffxc)
`ifdef BIST_MISR_EN
    , .SIGNATURE(sigc)
`endif
  );

  initial WCLK = 1'b0;
  always #5 WCLK = ~WCLK;

  // Memory model: history of issued reads, RDATA = expected ^ planted fault.
  logic       h_vld  [3];
  logic [3:0] h_addr [3];
  logic [7:0] h_exp  [3];
  logic [7:0] fault  [16];
  logic       shift2;

  always @(posedge WCLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < 3; k++) begin
        h_vld[k]  <= 1'b0;
        h_addr[k] <= 4'd0;
        h_exp[k]  <= 8'd0;
      end
    end else begin
      h_vld[0]  <= R_INC;
      h_addr[0] <= R_ADDR;
      h_exp[0]  <= EXPECTED;
      for (int k = 1; k < 3; k++) begin
        h_vld[k]  <= h_vld[k-1];
        h_addr[k] <= h_addr[k-1];
        h_exp[k]  <= h_exp[k-1];
      end
    end
  end

  always_comb begin
    rdata1 = h_vld[0] ? (h_exp[0] ^ fault[h_addr[0]]) : 8'hA5;
    if (shift2) rdata3 = h_vld[1] ? (h_exp[1] ^ fault[h_addr[1]]) : 8'hA5;
    else        rdata3 = h_vld[2] ? (h_exp[2] ^ fault[h_addr[2]]) : 8'hA5;
  end

  typedef struct {
    logic       pf;
    logic [7:0] cnt;
    logic [3:0] ffa;
    logic [7:0] ffx;
    logic [1:0] cnt2;
    logic       pf3;
    logic       chk3;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic       m_pf;
  logic [7:0] m_cnt;
  logic [3:0] m_ffa;
  logic [7:0] m_ffx;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 16; i++) fault[i] = 8'h00;
  endtask

  task automatic start_test();
    BIST_EN = 1'b1;
    START   = 1'b1;
    @(negedge WCLK);
    START   = 1'b0;
    m_pf = 1'b1; m_cnt = 8'd0; m_ffa = 4'd0; m_ffx = 8'd0;
  endtask

  // Issue reads first..last with gap idle cycles after each; push expectation on LAST.
  task automatic run_reads(input int first, input int last, input int gap,
                           input logic [7:0] expv, input bit mark_last);
    exp_t e;
    for (int i = first; i <= last; i++) begin
      R_INC    = 1'b1;
      R_ADDR   = 4'(i);
      EXPECTED = expv;
      LAST     = mark_last && (i == last);
      if (fault[i] != 8'h00) begin
        if (m_cnt == 8'd0) begin
          m_ffa = 4'(i);
          m_ffx = fault[i];
        end
        m_cnt = m_cnt + 8'd1;
        m_pf  = 1'b0;
      end
      @(negedge WCLK);
      R_INC = 1'b0;
      LAST  = 1'b0;
      repeat (gap) @(negedge WCLK);
    end
    if (mark_last) begin
      e.pf   = m_pf;
      e.cnt  = m_cnt;
      e.ffa  = m_ffa;
      e.ffx  = m_ffx;
      e.cnt2 = (m_cnt > 8'd3) ? 2'd3 : m_cnt[1:0];
      e.pf3  = shift2 ? 1'b0 : m_pf;
      e.chk3 = !shift2;
      sb_q.push_back(e);
    end
  endtask

  // Bounded wait for all instances to finish, then score against the queue head.
  task automatic wait_and_score(input string tag);
    exp_t e;
    int   c;
    c = 0;
    while (!(done1 && done3 && donec) && c < 64) begin
      @(negedge WCLK);
      c++;
    end
    check_eq({tag, "_done_seen"}, 32'(done1 && done3 && donec), 32'd1);
    check_eq({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_eq({tag, "_passfail"}, 32'(pf1), 32'(e.pf));
      check_eq({tag, "_fail_cnt"}, 32'(cnt1), 32'(e.cnt));
      check_eq({tag, "_ff_addr"}, 32'(ffa1), 32'(e.ffa));
      check_eq({tag, "_ff_xor"}, 32'(ffx1), 32'(e.ffx));
      check_eq({tag, "_cnt_sat"}, 32'(cntc), 32'(e.cnt2));
      check_eq({tag, "_passfail_l3"}, 32'(pf3), 32'(e.pf3));
      if (e.chk3) check_eq({tag, "_fail_cnt_l3"}, 32'(cnt3), 32'(e.cnt));
      check_eq({tag, "_busy"}, 32'(busy1), 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_passfail"}, 32'(pf1), 32'd1);
    check_eq({tag, "_done"}, 32'(done1), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy1), 32'd0);
    check_eq({tag, "_fail_cnt"}, 32'(cnt1), 32'd0);
    check_eq({tag, "_ff_addr"}, 32'(ffa1), 32'd0);
    check_eq({tag, "_ff_xor"}, 32'(ffx1), 32'd0);
    check_eq({tag, "_fail_cnt_l3"}, 32'(cnt3), 32'd0);
`ifdef BIST_MISR_EN
    check_eq({tag, "_signature"}, 32'(sig1), 32'hFF);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; BIST_EN = 1'b0; START = 1'b0; R_INC = 1'b0; LAST = 1'b0;
    R_ADDR = 4'd0; EXPECTED = 8'd0; shift2 = 1'b0;
    clear_faults();
    #1;
    check_reset_outputs("reset");
    #20;
    @(negedge WCLK);
    RST = 1'b0;
    @(negedge WCLK);

    // Clean run with exact DONE/BUSY timing at latency 1.
    start_test();
    check_eq("start_busy", 32'(busy1), 32'd1);
    run_reads(0, 15, 0, 8'h55, 1'b1);
    @(negedge WCLK);
    check_eq("clean_done_early", 32'(done1), 32'd0);
    check_eq("clean_busy_drain", 32'(busy1), 32'd1);
    @(negedge WCLK);
    check_eq("clean_done_time", 32'(done1), 32'd1);
    check_eq("clean_busy_low", 32'(busy1), 32'd0);
    wait_and_score("clean");
    repeat (3) @(negedge WCLK);
    check_eq("done_holds", 32'(done1), 32'd1);

    // Single fault.
    clear_faults();
    fault[6] = 8'h02;
    start_test();
    check_eq("restart_done_clr", 32'(done1), 32'd0);
    run_reads(0, 15, 0, 8'h55, 1'b1);
    wait_and_score("single");

    // Two faults: first one captured, second only counted.
    clear_faults();
    fault[3] = 8'h80;
    fault[9] = 8'h01;
    start_test();
    run_reads(0, 15, 0, 8'h55, 1'b1);
    wait_and_score("multi");

    // Five faults: 2-bit counter saturates at 3.
    clear_faults();
    fault[1] = 8'h10; fault[2] = 8'h20; fault[4] = 8'h40; fault[8] = 8'h08; fault[12] = 8'h01;
    start_test();
    run_reads(0, 15, 0, 8'h55, 1'b1);
    wait_and_score("sat");

    // Latency 3 with idle gaps, correctly aligned data.
    clear_faults();
    start_test();
    run_reads(0, 7, 2, 8'h55, 1'b1);
    wait_and_score("gaps_ok");

    // Same run with memory data one cycle early for the latency-3 instance.
    shift2 = 1'b1;
    start_test();
    run_reads(0, 7, 2, 8'h55, 1'b1);
    wait_and_score("gaps_shift");
    shift2 = 1'b0;
    repeat (4) @(negedge WCLK);

    // START during RUN is ignored.
    clear_faults();
    fault[2] = 8'h04;
    start_test();
    run_reads(0, 7, 0, 8'h55, 1'b0);
    START = 1'b1;
    @(negedge WCLK);
    START = 1'b0;
    check_eq("start_in_run_busy", 32'(busy1), 32'd1);
    check_eq("start_in_run_cnt", 32'(cnt1), 32'd1);
    run_reads(8, 15, 0, 8'h55, 1'b1);
    wait_and_score("start_in_run");

    // BIST_EN dropped mid-RUN: back to IDLE, results held.
    clear_faults();
    fault[1] = 8'h08;
    start_test();
    run_reads(0, 5, 0, 8'h55, 1'b0);
    BIST_EN = 1'b0;
    @(negedge WCLK);
    check_eq("en_drop_busy", 32'(busy1), 32'd0);
    check_eq("en_drop_done", 32'(done1), 32'd0);
    check_eq("en_drop_passfail", 32'(pf1), 32'd0);
    check_eq("en_drop_cnt", 32'(cnt1), 32'd1);
    check_eq("en_drop_ff_addr", 32'(ffa1), 32'd1);
    check_eq("en_drop_ff_xor", 32'(ffx1), 32'h08);
    check_eq("en_drop_cnt_l3", 32'(cnt3), 32'd1);
    BIST_EN = 1'b1;
    repeat (2) @(negedge WCLK);
    check_eq("en_back_idle", 32'(busy1), 32'd0);
    check_eq("en_back_held", 32'(cnt1), 32'd1);

    // Async reset mid-RUN clears outputs before the next edge.
    clear_faults();
    fault[0] = 8'h11;
    start_test();
    run_reads(0, 4, 0, 8'h55, 1'b0);
    check_eq("pre_rst_cnt", 32'(cnt1), 32'd1);
    RST = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge WCLK);
    RST = 1'b0;
    repeat (4) @(negedge WCLK);

`ifdef BIST_MISR_EN
    // One all-zero read folds the all-ones seed into 0x46; restart reseeds.
    clear_faults();
    start_test();
    run_reads(0, 0, 0, 8'h00, 1'b1);
    wait_and_score("misr");
    check_eq("misr_signature", 32'(sig1), 32'h46);
    start_test();
    check_eq("misr_reseed", 32'(sig1), 32'hFF);
    R_INC = 1'b0;
    repeat (2) @(negedge WCLK);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
